alu_result_buffer: RTL and testbench
====================================

// Module: alu_result_buffer
// PURPOSE
//  Registered result stage directly downstream of the 32-bit combinational ALU.
//  Captures result/flags with the destination tag and PC into a small FIFO.
//  Presents them to writeback over a valid/ready handshake.
//  Detects signed-overflow traps on ADD/SUB and holds a sticky exception until software clears it.
// PARAMETERS
//  WIDTH  32  datapath width; must match ALU result width
//  TAG_W  5   destination register tag width
//  DEPTH  2   FIFO entries; power of two, >= 2
// PORTS
//  clk           in   1      sole clock; all state updates on rising edge
//  reset         in   1      synchronous, active-high
//  in_valid      in   1      ALU outputs + sideband valid this cycle
//  in_ready      out  1      buffer accepts this cycle
//  in_result     in   WIDTH  ALU result
//  in_carryout   in   1      ALU carry out
//  in_zero       in   1      ALU zero flag
//  in_overflow   in   1      ALU overflow (already 0 for logic ops)
//  in_command    in   3      ALU command: 0 ADD,1 SUB,2 XOR,3 SLT,4 AND,5 NAND,6 NOR,7 OR
//  in_trap_en    in   1      1 = signed op (ADD/SUB trap on overflow); 0 = unsigned variant
//  in_dest       in   TAG_W  destination register
//  in_pc         in   WIDTH  PC of the instruction
//  out_valid     out  1      head entry valid
//  out_ready     in   1      writeback consumes head
//  out_result    out  WIDTH  head result
//  out_carryout  out  1      head carry
//  out_zero      out  1      head zero
//  out_dest      out  TAG_W  head destination
//  out_wr_en     out  1      head may write the register file (0 for trapped entry)
//  exc_pending   out  1      sticky overflow exception
//  exc_pc        out  WIDTH  PC of trapping instruction
//  exc_cmd       out  3      command of trapping instruction
//  exc_clear     in   1      clears exc_pending
// BEHAVIOUR
//  Reset
//   - count = 0, rd/wr ptr = 0, exc_pending = 0, exc_pc = 0, exc_cmd = 0.
//   - Outputs: out_valid = 0; out_* data = 0 (head RAM cleared).
//   - Reset mid-stream discards all entries and any pending exception.
//  Handshake
//   - push = in_valid & in_ready; pop = out_valid & out_ready.
//   - in_ready = (count != DEPTH) & ~exc_pending; pure function of registered state.
//   - out_valid = (count != 0). Head fields are driven from the entry at rd_ptr.
//   - No combinational in->out bypass: latency is 1 cycle from push to out_valid.
//   - Push and pop in the same cycle: count unchanged; both pointers advance modulo DEPTH.
//   - Full: in_ready = 0, so a push is impossible. Empty: pop is impossible.
//   - Head data is stable while out_valid & ~out_ready.
//  Trap detection (evaluated on push only)
//   - trap = in_overflow & in_trap_en & (in_command == ADD | in_command == SUB).
//   - SLT and logic commands never trap, whatever in_overflow is.
//   - On trap: entry enqueued with wr_en = 0.
//     Next cycle: exc_pending = 1, exc_pc = in_pc, exc_cmd = in_command.
//   - On a non-trapping push: entry enqueued with wr_en = 1.
//   - While exc_pending = 1, in_ready = 0. Older and trapped entries still drain normally.
//   - exc_clear with exc_pending = 1: exc_pending = 0 next cycle; exc_pc and exc_cmd retained.
//   - exc_clear with exc_pending = 0: no effect. A push cannot coincide with a pending exception.
//  Widths
//   - Pointers are log2(DEPTH) bits and wrap naturally.
//   - count is log2(DEPTH)+1 bits.
// STRUCTURE
//  - Shared package/header: ALU command codes (ADD..OR) and the DEPTH log2 helper.
//    Reused by the ALU control table and decode.
//  - One natural sub-module: result_fifo (storage, pointers, count, valid/ready).
//    Its entry = {result, carryout, zero, dest, wr_en}.
//  - Top level holds the trap detector and the exception registers.
// TESTING
//  1. Reset asserted mid-traffic with 2 entries held -> next cycle:
//     out_valid = 0, in_ready = 1, exc_pending = 0.
//  2. Push ADD result 0x00000005, dest 3, out_ready = 1 ->
//     next cycle out_valid = 1, out_result = 5, out_dest = 3, out_wr_en = 1; empty after pop.
//  3. out_ready = 0, push 3 entries (A, B, C) ->
//     in_ready falls after 2; C is held off; drain order is A then B.
//     Simultaneous push/pop at count = 1 keeps count = 1.
//  4. Push ADD with in_overflow = 1, in_trap_en = 1, pc 0x00400020 ->
//     entry out_wr_en = 0; exc_pending = 1; exc_pc = 0x00400020; exc_cmd = 0; in_ready = 0.
//     Pulse exc_clear -> in_ready = 1 next cycle.
//  5. Push SLT with in_overflow = 1, then SUB with in_overflow = 1, in_trap_en = 0 ->
//     both out_wr_en = 1, exc_pending stays 0.
//  6. Random valid/ready toggling over 10k pushes against a reference queue ->
//     order preserved, no loss or duplication, head stable while stalled.

Source files
------------

// File: rtl/alu_result_buffer_pkg.sv
// Package shared by the ALU result stage and the ALU control/decode logic.
// Holds the ALU command encoding and a ceil(log2) helper used to size
// FIFO pointers and occupancy counters.
package alu_result_buffer_pkg;

  typedef enum logic [2:0] {
    CMD_ADD  = 3'd0,
    CMD_SUB  = 3'd1,
    CMD_XOR  = 3'd2,
    CMD_SLT  = 3'd3,
    CMD_AND  = 3'd4,
    CMD_NAND = 3'd5,
    CMD_NOR  = 3'd6,
    CMD_OR   = 3'd7
  } alu_cmd_e;

  // Smallest r with 2**r >= n (n >= 1).
  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_result_buffer_if.sv
// Bus bundle between the ALU/issue side, the result buffer and writeback.
//   in_*        ALU result, flags and sideband (command, trap enable, tag, PC)
//   out_*       head of the result buffer toward writeback
//   exc_*       sticky overflow exception status and its clear
// Modports:
//   master : environment side (drives ALU inputs, out_ready, exc_clear)
//   slave  : the result buffer
//
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both 1. in_ready and out_valid depend only on registered state, so a
// source may look at ready before deciding on valid. Once out_valid is high
// the head fields are held unchanged until out_ready takes them.
interface alu_result_buffer_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_carryout;
  logic             in_zero;
  logic             in_overflow;
  logic [2:0]       in_command;
  logic             in_trap_en;
  logic [TAG_W-1:0] in_dest;
  logic [WIDTH-1:0] in_pc;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carryout;
  logic             out_zero;
  logic [TAG_W-1:0] out_dest;
  logic             out_wr_en;

  logic             exc_pending;
  logic [WIDTH-1:0] exc_pc;
  logic [2:0]       exc_cmd;
  logic             exc_clear;

  modport master (
    output in_valid, in_result, in_carryout, in_zero, in_overflow,
           in_command, in_trap_en, in_dest, in_pc, out_ready, exc_clear,
    input  in_ready, out_valid, out_result, out_carryout, out_zero,
           out_dest, out_wr_en, exc_pending, exc_pc, exc_cmd
  );

  modport slave (
    input  in_valid, in_result, in_carryout, in_zero, in_overflow,
           in_command, in_trap_en, in_dest, in_pc, out_ready, exc_clear,
    output in_ready, out_valid, out_result, out_carryout, out_zero,
           out_dest, out_wr_en, exc_pending, exc_pc, exc_cmd
  );
endinterface

// File: rtl/alu_result_buffer_result_fifo.sv
// Small synchronous FIFO holding packed result entries.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   push         write push_data this cycle (ignored when full)
//   push_data    entry to enqueue
//   not_full     space available (registered-state function)
//   pop          head consumed this cycle (ignored when empty)
//   valid        head entry present (registered-state function)
//   head         entry at the read pointer
// Storage is cleared on reset so the head reads as zero afterwards.
module alu_result_buffer_result_fifo
  import alu_result_buffer_pkg::*;
#(
  parameter int W     = 40,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         not_full,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] head
);
  localparam int AW = log2_ceil(DEPTH);
  localparam logic [AW:0]   FULL_C  = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign not_full = (count != FULL_C);
  assign valid    = (count != '0);
  assign do_push  = push & not_full;
  assign do_pop   = pop & valid;
  assign head     = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap without explicit modulo.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/alu_result_buffer.sv
// Registered result stage directly after the combinational ALU.
// Captures result/flags with destination tag into a small FIFO, presents the
// head to writeback, and raises a sticky exception on signed ADD/SUB overflow.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset; drops all entries and exceptions
//   bus    alu_result_buffer_if.slave (in_*, out_*, exc_* signals)
module alu_result_buffer
  import alu_result_buffer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_result_buffer_if.slave   bus
);
  // Entry layout: {result, carryout, zero, dest, wr_en}
  localparam int EW = WIDTH + 3 + TAG_W;

  logic          trap;
  logic          push;
  logic          pop;
  logic          fifo_not_full;
  logic          fifo_valid;
  logic [EW-1:0] push_entry;
  logic [EW-1:0] head_entry;

  logic             exc_pending_q;
  logic [WIDTH-1:0] exc_pc_q;
  logic [2:0]       exc_cmd_q;

  // Only signed ADD/SUB trap; the ALU may still report overflow for SLT.
  assign trap = bus.in_overflow & bus.in_trap_en &
                ((bus.in_command == CMD_ADD) | (bus.in_command == CMD_SUB));

  // A pending exception stalls issue until software acknowledges it;
  // entries already buffered keep draining.
  assign bus.in_ready = fifo_not_full & ~exc_pending_q;
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = fifo_valid & bus.out_ready;

  // The trapping instruction still flows to writeback, but without a
  // register-file write.
  assign push_entry = {bus.in_result, bus.in_carryout, bus.in_zero,
                       bus.in_dest, ~trap};

  alu_result_buffer_result_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .not_full  (fifo_not_full),
    .pop       (pop),
    .valid     (fifo_valid),
    .head      (head_entry)
  );

  assign bus.out_valid = fifo_valid;
  assign {bus.out_result, bus.out_carryout, bus.out_zero,
          bus.out_dest, bus.out_wr_en} = head_entry;

  // A push never coincides with a pending exception (in_ready is low), so
  // capture and clear cannot collide. PC/command stay after a clear for
  // post-mortem reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      exc_pending_q <= 1'b0;
      exc_pc_q      <= '0;
      exc_cmd_q     <= '0;
    end else if (push & trap) begin
      exc_pending_q <= 1'b1;
      exc_pc_q      <= bus.in_pc;
      exc_cmd_q     <= bus.in_command;
    end else if (bus.exc_clear & exc_pending_q) begin
      exc_pending_q <= 1'b0;
    end
  end

  assign bus.exc_pending = exc_pending_q;
  assign bus.exc_pc      = exc_pc_q;
  assign bus.exc_cmd     = exc_cmd_q;
endmodule

// File: tb/tb_alu_result_buffer.sv
module tb_alu_result_buffer;
  import alu_result_buffer_pkg::*;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;
  localparam int DEPTH = 2;
  localparam int EW    = WIDTH + 3 + TAG_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_result_buffer_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus();

  alu_result_buffer #(.WIDTH(WIDTH), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [EW-1:0]    exp_q[$];
  logic             m_pending;
  logic [WIDTH-1:0] m_pc;
  logic [2:0]       m_cmd;
  int checks = 0;
  int errors = 0;
  int pushes = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_in_ready();
    return (exp_q.size() < DEPTH) && !m_pending;
  endfunction

  task automatic check_state();
    logic [EW-1:0] head;
    check("in_ready", bus.in_ready, m_in_ready());
    check("out_valid", bus.out_valid, exp_q.size() != 0);
    check("exc_pending", bus.exc_pending, m_pending);
    check("exc_pc", bus.exc_pc, m_pc);
    check("exc_cmd", bus.exc_cmd, m_cmd);
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check("out_result", bus.out_result, head[EW-1 -: WIDTH]);
      check("out_carryout", bus.out_carryout, head[TAG_W+2]);
      check("out_zero", bus.out_zero, head[TAG_W+1]);
      check("out_dest", bus.out_dest, head[TAG_W:1]);
      check("out_wr_en", bus.out_wr_en, head[0]);
    end
  endtask

  // Check current state, then advance one clock and apply the driven inputs
  // to the model.
  task automatic tick();
    logic          trap, push, pop, rst, clr;
    logic [EW-1:0] entry;
    logic [WIDTH-1:0] pc;
    logic [2:0]    cmd;
    check_state();
    trap  = bus.in_overflow && bus.in_trap_en &&
            (bus.in_command == 3'd0 || bus.in_command == 3'd1);
    push  = bus.in_valid && m_in_ready();
    pop   = (exp_q.size() != 0) && bus.out_ready;
    rst   = reset;
    clr   = bus.exc_clear;
    pc    = bus.in_pc;
    cmd   = bus.in_command;
    entry = {bus.in_result, bus.in_carryout, bus.in_zero, bus.in_dest, !trap};
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      m_pending = 1'b0;
      m_pc      = '0;
      m_cmd     = '0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        exp_q.push_back(entry);
        pushes++;
      end
      if (push && trap) begin
        m_pending = 1'b1;
        m_pc      = pc;
        m_cmd     = cmd;
      end else if (clr && m_pending) begin
        m_pending = 1'b0;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [2:0] cmd,
                       input logic [WIDTH-1:0] res, input logic [TAG_W-1:0] dest,
                       input logic ovf, input logic ten, input logic [WIDTH-1:0] pc);
    bus.in_valid    = v;
    bus.in_command  = cmd;
    bus.in_result   = res;
    bus.in_dest     = dest;
    bus.in_overflow = ovf;
    bus.in_trap_en  = ten;
    bus.in_pc       = pc;
    bus.in_carryout = res[0];
    bus.in_zero     = (res == '0);
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int start, cyc;
    reset         = 1'b1;
    idle();
    bus.out_ready = 1'b0;
    bus.exc_clear = 1'b0;
    m_pending     = 1'b0;
    m_pc          = '0;
    m_cmd         = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_result", bus.out_result, '0);
    check("rst_out_dest", bus.out_dest, '0);
    check("rst_exc_pending", bus.exc_pending, 1'b0);

    // Reset mid-traffic with two entries held and an exception pending
    drive(1'b1, 3'd2, 32'h1234_5678, 5'd7, 1'b0, 1'b0, 32'h100); tick();
    drive(1'b1, 3'd0, 32'h8000_0000, 5'd8, 1'b1, 1'b1, 32'h104); tick();
    idle();
    reset = 1'b1; tick();
    reset = 1'b0;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_in_ready", bus.in_ready, 1'b1);
    check("midrst_exc_pending", bus.exc_pending, 1'b0);
    check("midrst_exc_pc", bus.exc_pc, '0);
    check("midrst_out_result", bus.out_result, '0);

    // Single ADD, 1-cycle latency, then drained
    bus.out_ready = 1'b1;
    drive(1'b1, 3'd0, 32'h5, 5'd3, 1'b0, 1'b1, 32'h200); tick();
    idle();
    check("add_out_valid", bus.out_valid, 1'b1);
    check("add_out_result", bus.out_result, 32'h5);
    check("add_out_dest", bus.out_dest, 5'd3);
    check("add_out_wr_en", bus.out_wr_en, 1'b1);
    tick();
    check("add_empty", bus.out_valid, 1'b0);

    // Fill to full, C held off, drain A then B, push/pop at count 1
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd7, 32'hAAAA_0001, 5'd1, 1'b0, 1'b0, 32'h300); tick();
    drive(1'b1, 3'd4, 32'hBBBB_0002, 5'd2, 1'b0, 1'b0, 32'h304); tick();
    drive(1'b1, 3'd6, 32'hCCCC_0003, 5'd4, 1'b0, 1'b0, 32'h308);
    check("full_in_ready", bus.in_ready, 1'b0);
    tick();
    check("full_hold_in_ready", bus.in_ready, 1'b0);
    check("full_head_A", bus.out_result, 32'hAAAA_0001);
    idle();
    bus.out_ready = 1'b1; tick();
    check("order_head_B", bus.out_result, 32'hBBBB_0002);
    drive(1'b1, 3'd6, 32'hCCCC_0003, 5'd4, 1'b0, 1'b0, 32'h308); tick();
    idle();
    check("pushpop_out_valid", bus.out_valid, 1'b1);
    check("pushpop_head_C", bus.out_result, 32'hCCCC_0003);
    check("pushpop_in_ready", bus.in_ready, 1'b1);
    tick();
    check("fill_empty", bus.out_valid, 1'b0);

    // Trapping ADD
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd0, 32'h7FFF_FFFF, 5'd9, 1'b1, 1'b1, 32'h0040_0020); tick();
    idle();
    check("trap_wr_en", bus.out_wr_en, 1'b0);
    check("trap_pending", bus.exc_pending, 1'b1);
    check("trap_exc_pc", bus.exc_pc, 32'h0040_0020);
    check("trap_exc_cmd", bus.exc_cmd, 3'd0);
    check("trap_in_ready", bus.in_ready, 1'b0);
    bus.exc_clear = 1'b1; tick();
    bus.exc_clear = 1'b0;
    check("clear_in_ready", bus.in_ready, 1'b1);
    check("clear_keeps_pc", bus.exc_pc, 32'h0040_0020);
    bus.out_ready = 1'b1; tick();

    // SLT with overflow and unsigned SUB with overflow: no trap
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd3, 32'h1, 5'd10, 1'b1, 1'b1, 32'h500); tick();
    drive(1'b1, 3'd1, 32'h8000_0001, 5'd11, 1'b1, 1'b0, 32'h504); tick();
    idle();
    check("slt_wr_en", bus.out_wr_en, 1'b1);
    check("slt_pending", bus.exc_pending, 1'b0);
    bus.out_ready = 1'b1; tick();
    check("subu_wr_en", bus.out_wr_en, 1'b1);
    check("subu_pending", bus.exc_pending, 1'b0);
    tick();

    // Random valid/ready traffic against the reference queue
    start = pushes;
    cyc   = 0;
    while ((pushes - start) < 10000 && cyc < 60000) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom(),
            5'($urandom_range(0, 31)), $urandom_range(0, 7) == 0,
            1'($urandom_range(0, 1)), $urandom());
      bus.in_carryout = 1'($urandom_range(0, 1));
      bus.out_ready   = ($urandom_range(0, 3) != 0);
      bus.exc_clear   = m_pending ? ($urandom_range(0, 3) == 0)
                                  : ($urandom_range(0, 15) == 0);
      tick();
      cyc++;
    end
    check("random_push_budget", (pushes - start) >= 10000, 1'b1);

    // Drain remaining entries
    idle();
    bus.out_ready = 1'b1;
    bus.exc_clear = 1'b1;
    repeat (4) tick();
    check("final_empty", bus.out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
